// File: rtl/wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_ctrl
// Description : Write-back stage controller. Non-load instructions commit on
//               the edge that accepts them. Loads park in WAIT_MEM until the
//               dcache responds, then the read data is lane-selected and
//               extended, and the result commits on the response edge.
//               Misaligned loads raise a one-cycle misalign_err pulse instead
//               of writing the register file.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : XLEN       data/register width (32 or 64)
//               NREG_BITS  register index width
// Ports       : clk, rst_n              clock, async active-low reset
//               valid_in / ready_out    upstream handshake
//               load_regfile, is_load, load_unsigned, load_type[1:0],
//               regfilemux_sel[2:0], rd  instruction control fields
//               alu, br, u_imm, pc      candidate result sources
//               dcache_resp, dcache_rdata  data cache response
//               rd_data, ld_regfile, rd_out  register-file write port
//               misalign_err            one-cycle misaligned-load pulse
// Option      : define WB_STAGE_CTRL_PERF_CNT_EN to add retire_cnt and
//               stall_cnt (32-bit wrapping performance counters).
// ============================================================================
module wb_stage_ctrl #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 load_regfile,
    input  logic                 is_load,
    input  logic                 load_unsigned,
    input  logic [1:0]           load_type,
    input  logic [2:0]           regfilemux_sel,
    input  logic [NREG_BITS-1:0] rd,
    input  logic [XLEN-1:0]      alu,
    input  logic [XLEN-1:0]      br,
    input  logic [XLEN-1:0]      u_imm,
    input  logic [XLEN-1:0]      pc,
    input  logic                 dcache_resp,
    input  logic [XLEN-1:0]      dcache_rdata,
    output logic [XLEN-1:0]      rd_data,
    output logic                 ld_regfile,
    output logic [NREG_BITS-1:0] rd_out,
`ifdef WB_STAGE_CTRL_PERF_CNT_EN
    output logic [31:0]          retire_cnt,
    output logic [31:0]          stall_cnt,
`endif
    output logic                 misalign_err
);

    // Number of address bits that select a byte lane within one XLEN word.
    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Fields captured when a load is accepted. Only the byte-offset bits of
    // the address are kept: nothing else of alu is needed once in WAIT_MEM.
    logic [NREG_BITS-1:0] lat_rd,            lat_rd_nxt;
    logic [1:0]           lat_type,          lat_type_nxt;
    logic                 lat_unsigned,      lat_unsigned_nxt;
    logic                 lat_load_regfile,  lat_load_regfile_nxt;
    logic [OFFW-1:0]      lat_offset,        lat_offset_nxt;

    logic [XLEN-1:0]      rd_data_nxt;
    logic [NREG_BITS-1:0] rd_out_nxt;
    logic                 ld_regfile_nxt;
    logic                 misalign_err_nxt;

    logic [XLEN-1:0]      mux_val;
    logic [XLEN-1:0]      shifted;
    logic [XLEN-1:0]      lane_mask;
    logic                 lane_sign;
    logic                 load_err;
    logic [XLEN-1:0]      load_val;

    assign ready_out = (state == IDLE);

    // ------------------------------------------------------------------
    // Non-load result select. Unused encodings produce zero.
    // ------------------------------------------------------------------
    always_comb begin
        mux_val = '0;
        case (regfilemux_sel)
            3'd0:    mux_val = alu;
            3'd1:    mux_val = br;
            3'd2:    mux_val = u_imm;
            3'd4:    mux_val = pc + {{(XLEN-3){1'b0}}, 3'd4};
            default: mux_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane select and extension. The addressed byte is shifted down
    // to bit 0, then masked to the access width; signed loads fill the
    // bits above the mask with the access's top bit.
    // ------------------------------------------------------------------
    always_comb begin
        shifted   = dcache_rdata >> {lat_offset, 3'b000};
        lane_mask = '1;
        lane_sign = 1'b0;
        load_err  = 1'b0;
        case (lat_type)
            2'd0: begin
                lane_mask = {XLEN{1'b1}} >> (XLEN - 8);
                lane_sign = shifted[7];
            end
            2'd1: begin
                lane_mask = {XLEN{1'b1}} >> (XLEN - 16);
                lane_sign = shifted[15];
                load_err  = lat_offset[0];
            end
            2'd2: begin
                lane_mask = {XLEN{1'b1}} >> (XLEN - 32);
                lane_sign = shifted[31];
                load_err  = |lat_offset[1:0];
            end
            default: begin
                // Doubleword: full width, only legal on a 64-bit datapath.
                lane_mask = '1;
                lane_sign = 1'b0;
                load_err  = (XLEN != 64) || (lat_offset != '0);
            end
        endcase
        load_val = shifted & lane_mask;
        if (!lat_unsigned && lane_sign) begin
            load_val = load_val | ~lane_mask;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Pulse outputs default low so an
    // idle cycle drops them while rd_data/rd_out hold.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt            = state;
        rd_data_nxt          = rd_data;
        rd_out_nxt           = rd_out;
        ld_regfile_nxt       = 1'b0;
        misalign_err_nxt     = 1'b0;
        lat_rd_nxt           = lat_rd;
        lat_type_nxt         = lat_type;
        lat_unsigned_nxt     = lat_unsigned;
        lat_load_regfile_nxt = lat_load_regfile;
        lat_offset_nxt       = lat_offset;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (is_load) begin
                        lat_rd_nxt           = rd;
                        lat_type_nxt         = load_type;
                        lat_unsigned_nxt     = load_unsigned;
                        lat_load_regfile_nxt = load_regfile;
                        lat_offset_nxt       = alu[OFFW-1:0];
                        state_nxt            = WAIT_MEM;
                    end else begin
                        rd_data_nxt    = mux_val;
                        rd_out_nxt     = rd;
                        // x0 is hard-wired: never request a write to it.
                        ld_regfile_nxt = load_regfile && (rd != '0);
                    end
                end
            end
            WAIT_MEM: begin
                if (dcache_resp) begin
                    state_nxt  = IDLE;
                    rd_out_nxt = lat_rd;
                    if (load_err) begin
                        misalign_err_nxt = 1'b1;
                        rd_data_nxt      = '0;
                    end else begin
                        rd_data_nxt    = load_val;
                        ld_regfile_nxt = lat_load_regfile && (lat_rd != '0);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rd_data          <= '0;
            rd_out           <= '0;
            ld_regfile       <= 1'b0;
            misalign_err     <= 1'b0;
            lat_rd           <= '0;
            lat_type         <= '0;
            lat_unsigned     <= 1'b0;
            lat_load_regfile <= 1'b0;
            lat_offset       <= '0;
        end else begin
            state            <= state_nxt;
            rd_data          <= rd_data_nxt;
            rd_out           <= rd_out_nxt;
            ld_regfile       <= ld_regfile_nxt;
            misalign_err     <= misalign_err_nxt;
            lat_rd           <= lat_rd_nxt;
            lat_type         <= lat_type_nxt;
            lat_unsigned     <= lat_unsigned_nxt;
            lat_load_regfile <= lat_load_regfile_nxt;
            lat_offset       <= lat_offset_nxt;
        end
    end

`ifdef WB_STAGE_CTRL_PERF_CNT_EN
    // Counters observe the registered pulses and state, so each retire is
    // counted on the edge after it becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (ld_regfile || misalign_err) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (state == WAIT_MEM) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_ctrl
// Description : Directed self-checking bench for wb_stage_ctrl (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_ctrl;

    localparam int XLEN      = 32;
    localparam int NREG_BITS = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_in;
    logic                 ready_out;
    logic                 load_regfile;
    logic                 is_load;
    logic                 load_unsigned;
    logic [1:0]           load_type;
    logic [2:0]           regfilemux_sel;
    logic [NREG_BITS-1:0] rd;
    logic [XLEN-1:0]      alu;
    logic [XLEN-1:0]      br;
    logic [XLEN-1:0]      u_imm;
    logic [XLEN-1:0]      pc;
    logic                 dcache_resp;
    logic [XLEN-1:0]      dcache_rdata;
    logic [XLEN-1:0]      rd_data;
    logic                 ld_regfile;
    logic [NREG_BITS-1:0] rd_out;
    logic                 misalign_err;
`ifdef WB_STAGE_CTRL_PERF_CNT_EN
    logic [31:0]          retire_cnt;
    logic [31:0]          stall_cnt;
`endif

    int n_cmp;
    int n_err;

    wb_stage_ctrl #(.XLEN(XLEN), .NREG_BITS(NREG_BITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .load_regfile   (load_regfile),
        .is_load        (is_load),
        .load_unsigned  (load_unsigned),
        .load_type      (load_type),
        .regfilemux_sel (regfilemux_sel),
        .rd             (rd),
        .alu            (alu),
        .br             (br),
        .u_imm          (u_imm),
        .pc             (pc),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .rd_data        (rd_data),
        .ld_regfile     (ld_regfile),
        .rd_out         (rd_out),
`ifdef WB_STAGE_CTRL_PERF_CNT_EN
        .retire_cnt     (retire_cnt),
        .stall_cnt      (stall_cnt),
`endif
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a non-load instruction.
    task automatic op_alu(input logic [2:0] sel, input logic [4:0] r, input logic [31:0] a);
        valid_in       = 1'b1;
        is_load        = 1'b0;
        load_regfile   = 1'b1;
        regfilemux_sel = sel;
        rd             = r;
        alu            = a;
    endtask

    // Present a load instruction.
    task automatic op_load(input logic [1:0] t, input logic u, input logic [4:0] r, input logic [31:0] a);
        valid_in      = 1'b1;
        is_load       = 1'b1;
        load_regfile  = 1'b1;
        load_type     = t;
        load_unsigned = u;
        rd            = r;
        alu           = a;
    endtask

    // Accept a load, wait one extra cycle, respond, and check the commit.
    task automatic run_load(input string tag, input logic [1:0] t, input logic u, input logic [4:0] r,
                            input logic [31:0] a, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic exp_ld, input logic exp_err);
        op_load(t, u, r, a);
        tick();
        valid_in = 1'b0;
        tick();
        dcache_resp  = 1'b1;
        dcache_rdata = rdata;
        tick();
        dcache_resp = 1'b0;
        check({tag, "_data"}, rd_data, exp_data);
        check({tag, "_ld"}, ld_regfile, exp_ld);
        check({tag, "_err"}, misalign_err, exp_err);
        check({tag, "_rdy"}, ready_out, 1'b1);
        tick();
        check({tag, "_err_off"}, misalign_err, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        valid_in = 1'b0; load_regfile = 1'b0; is_load = 1'b0; load_unsigned = 1'b0;
        load_type = 2'd0; regfilemux_sel = 3'd0; rd = '0;
        alu = '0; br = '0; u_imm = '0; pc = '0;
        dcache_resp = 1'b0; dcache_rdata = '0;

        #12;
        check("rst_rd_data", rd_data, 0);
        check("rst_ld", ld_regfile, 0);
        check("rst_rd_out", rd_out, 0);
        check("rst_err", misalign_err, 0);
        check("rst_ready", ready_out, 1);
`ifdef WB_STAGE_CTRL_PERF_CNT_EN
        check("rst_retire", retire_cnt, 0);
        check("rst_stall", stall_cnt, 0);
`endif
        rst_n = 1'b1;

        // pc+4 on the first edge after reset release
        op_alu(3'd4, 5'd3, 32'h0);
        pc = 32'h100;
        tick();
        check("pc4_data", rd_data, 32'h104);
        check("pc4_ld", ld_regfile, 1);
        check("pc4_rd", rd_out, 3);
        valid_in = 1'b0;
        tick();
        check("idle_ld", ld_regfile, 0);
        check("idle_hold_data", rd_data, 32'h104);
        check("idle_hold_rd", rd_out, 3);

        // back-to-back mux sources
        br = 32'hB0B0_0001; u_imm = 32'hABCD_E000;
        op_alu(3'd0, 5'd1, 32'h1234_5678); tick();
        check("mux_alu", rd_data, 32'h1234_5678);
        op_alu(3'd1, 5'd2, 32'h0); tick();
        check("mux_br", rd_data, 32'hB0B0_0001);
        op_alu(3'd2, 5'd4, 32'h0); tick();
        check("mux_uimm", rd_data, 32'hABCD_E000);
        check("mux_uimm_ld", ld_regfile, 1);
        op_alu(3'd5, 5'd6, 32'h0); tick();
        check("mux_sel5", rd_data, 0);
        pc = 32'hFFFF_FFFC;
        op_alu(3'd4, 5'd7, 32'h0); tick();
        check("mux_pc_wrap", rd_data, 0);

        // rd = 0 never writes
        op_alu(3'd0, 5'd0, 32'h55); tick();
        check("x0_ld", ld_regfile, 0);
        check("x0_rd", rd_out, 0);
        check("x0_data", rd_data, 32'h55);

        // signed byte load, 3 stall cycles, next instruction held upstream
        op_load(2'd0, 1'b0, 5'd5, 32'h1003);
        tick();
        check("lb_acc_rdy", ready_out, 0);
        check("lb_acc_ld", ld_regfile, 0);
        op_alu(3'd0, 5'd7, 32'h0000_DEAD);
        tick();
        check("lb_wait1_rdy", ready_out, 0);
        check("lb_wait1_rd", rd_out, 0);
        tick();
        check("lb_wait2_rdy", ready_out, 0);
        dcache_resp  = 1'b1;
        dcache_rdata = 32'h80FF_FF00;
        tick();
        dcache_resp = 1'b0;
        check("lb_data", rd_data, 32'hFFFF_FF80);
        check("lb_ld", ld_regfile, 1);
        check("lb_rd", rd_out, 5);
        check("lb_rdy", ready_out, 1);
        tick();
        check("held_data", rd_data, 32'h0000_DEAD);
        check("held_rd", rd_out, 7);
        check("held_ld", ld_regfile, 1);
        valid_in = 1'b0;

        run_load("lhu",  2'd1, 1'b1, 5'd8,  32'h2002, 32'h8001_1234, 32'h0000_8001, 1'b1, 1'b0);
        run_load("lh",   2'd1, 1'b0, 5'd9,  32'h2000, 32'h0000_F00D, 32'hFFFF_F00D, 1'b1, 1'b0);
        run_load("lbu",  2'd0, 1'b1, 5'd10, 32'h2001, 32'h0000_9A00, 32'h0000_009A, 1'b1, 1'b0);
        run_load("lw",   2'd2, 1'b0, 5'd11, 32'h3000, 32'h8765_4321, 32'h8765_4321, 1'b1, 1'b0);
        run_load("mis_h", 2'd1, 1'b0, 5'd12, 32'h1001, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        run_load("mis_w", 2'd2, 1'b0, 5'd13, 32'h1002, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        run_load("ld_d32", 2'd3, 1'b0, 5'd14, 32'h1000, 32'h1234_5678, 32'h0, 1'b0, 1'b1);

        // dcache_resp in IDLE is ignored
        dcache_resp = 1'b1; dcache_rdata = 32'hFFFF_FFFF;
        tick();
        dcache_resp = 1'b0;
        check("idle_resp_ld", ld_regfile, 0);
        check("idle_resp_data", rd_data, 0);
        check("idle_resp_rdy", ready_out, 1);

        // reset while waiting discards the load
        op_load(2'd2, 1'b0, 5'd15, 32'h4000);
        tick();
        valid_in = 1'b0;
        check("rw_wait_rdy", ready_out, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_async_rdy", ready_out, 1);
        check("rw_async_rd", rd_out, 0);
        rst_n = 1'b1;
        dcache_resp = 1'b1; dcache_rdata = 32'h1111_2222;
        tick();
        dcache_resp = 1'b0;
        check("rw_resp_ld", ld_regfile, 0);
        check("rw_resp_rdy", ready_out, 1);
        check("rw_resp_data", rd_data, 0);

`ifdef WB_STAGE_CTRL_PERF_CNT_EN
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        op_alu(3'd0, 5'd1, 32'h1); tick();
        op_alu(3'd0, 5'd2, 32'h2); tick();
        op_load(2'd2, 1'b0, 5'd3, 32'h0); tick();
        valid_in = 1'b0;
        tick();
        dcache_resp = 1'b1; dcache_rdata = 32'h77;
        tick();
        dcache_resp = 1'b0;
        tick();
        check("perf_retire", retire_cnt, 3);
        check("perf_stall", stall_cnt, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wb_stage_ctrl.md
WB_STAGE_CTRL -- requirements
Module: wb_stage_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, register/data width; legal values 32 or 64.
REQ-002 SHALL have parameter NREG_BITS, default 5, register-index width.
REQ-003 SHALL have ports clk (input, 1, sole clock, rising edge) and rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have port valid_in (input, 1): instruction present from the memory stage.
REQ-005 SHALL have port ready_out (input-side handshake output, 1): stage can accept the instruction this cycle.
REQ-006 SHALL have control inputs, each 1 bit unless stated: load_regfile, is_load, load_unsigned, load_type (2: 0 byte, 1 half, 2 word, 3 double), regfilemux_sel (3), rd (NREG_BITS).
REQ-007 SHALL have XLEN-bit data inputs alu, br, u_imm and pc.
REQ-008 SHALL have dcache ports dcache_resp (input, 1) and dcache_rdata (input, XLEN).
REQ-009 SHALL have outputs rd_data (XLEN), ld_regfile (1), rd_out (NREG_BITS), misalign_err (1, one-cycle pulse).

Function
REQ-010 SHALL implement FSM states IDLE and WAIT_MEM.
REQ-011 Handshake SHALL be: transfer occurs on a rising edge when valid_in and ready_out are both 1; ready_out SHALL be 1 in IDLE and 0 in WAIT_MEM.
REQ-012 Non-load transfer SHALL register outputs on the same edge: latency 1 cycle; state stays IDLE.
REQ-013 Non-load rd_data SHALL be selected by regfilemux_sel: 0 alu, 1 br, 2 u_imm, 4 pc+4 (mod 2^XLEN); 3, 5, 6 and 7 SHALL yield 0.
REQ-014 Load transfer SHALL latch the control fields and alu, move to WAIT_MEM, and drive ld_regfile 0.
REQ-015 In WAIT_MEM, dcache_resp=1 SHALL mask dcache_rdata, register the result, assert ld_regfile for 1 cycle, and return to IDLE on that edge.
REQ-016 The dcache_resp and commit edge SHALL be the same edge; a new instruction SHALL be accepted on the following edge at the earliest.
REQ-017 Masking SHALL select lanes using the byte offset alu[log2(XLEN/8)-1:0]: byte at any offset; half at even offsets; word at offsets that are multiples of 4; double only when XLEN=64 and offset 0.
REQ-018 Masking SHALL sign-extend to XLEN, or zero-extend when load_unsigned=1.
REQ-019 Misaligned access, or load_type=3 with XLEN=32, SHALL pulse misalign_err, force ld_regfile=0 and rd_data=0, and still exit WAIT_MEM normally.
REQ-020 ld_regfile SHALL be 0 whenever rd_out=0, for both loads and non-loads.
REQ-021 ld_regfile SHALL be a single-cycle pulse per committed instruction; an idle cycle (no transfer, no commit) SHALL drive ld_regfile=0 while rd_data and rd_out hold their last value.
REQ-022 dcache_resp asserted in IDLE SHALL be ignored.
REQ-023 valid_in asserted in WAIT_MEM SHALL NOT be consumed; upstream holds it.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, ld_regfile 0, rd_data 0, rd_out 0, misalign_err 0, and all latched fields 0.
REQ-025 Reset in WAIT_MEM SHALL discard the pending load; a dcache_resp arriving after reset release SHALL be ignored.
REQ-026 The first transfer SHALL be possible on the first rising edge after rst_n rises.

Configuration
REQ-027 Macro WB_STAGE_CTRL_PERF_CNT_EN, when defined, SHALL add outputs retire_cnt (32) and stall_cnt (32).
REQ-028 With the macro, retire_cnt SHALL increment on each ld_regfile pulse and on each misalign_err pulse; stall_cnt SHALL increment on each cycle spent in WAIT_MEM; both SHALL wrap at 2^32 and reset to 0.
REQ-029 Without the macro, neither counter nor its ports SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-030 SHALL test: XLEN=32, regfilemux_sel=4, pc=0x100, rd=3 -> next cycle rd_data=0x104, ld_regfile=1 for 1 cycle.
REQ-031 SHALL test: load byte signed, alu=0x1003, dcache_rdata=0x80FF_FF00, dcache_resp 3 cycles later -> ready_out=0 for 3 cycles, then rd_data=0xFFFF_FF80, ld_regfile pulse.
REQ-032 SHALL test: load half, alu=0x1001 -> misalign_err pulse, ld_regfile=0, return to IDLE.
REQ-033 SHALL test: alu op with rd=0 -> ld_regfile stays 0.
REQ-034 SHALL test: rst_n low in WAIT_MEM, then dcache_resp after release -> no ld_regfile pulse, ready_out=1.
REQ-035 SHALL test, with the macro defined: 2 ALU ops and 1 load with a 2-cycle wait -> retire_cnt=3, stall_cnt=2.
